// File: rtl/ram_bist_ctrl.sv
// March-test sequencer for a small synchronous RAM: write/read ascending, write/read
// inverted descending, then report pass/fail, first failing address/data and error count.
module ram_bist_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW+1:0] err_cnt,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic          ram_wr,
    output logic          ram_rd,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [2:0] {IDLE, WR_UP, RD_UP, WR_DN, RD_DN, DRAIN, FIN} state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(a) + DW'(1);
    endfunction

    state_t          state, state_n;
    logic [2:0]      drain_cnt, drain_n;
    logic            busy_n, done_n, pass_n, wr_n, rd_n;
    logic [AW+1:0]   err_n;
    logic [AW-1:0]   fail_addr_n, add_n, add_inc, add_dec;
    logic [DW-1:0]   fail_data_n, din_n;

    // Compare pipeline: one stage per cycle of RAM read latency.
    logic [RD_LAT-1:0] pipe_vld;
    logic [AW-1:0]     pipe_addr [RD_LAT];
    logic [DW-1:0]     pipe_exp  [RD_LAT];
    logic              mismatch;

    assign add_inc  = ram_add + 1'b1;
    assign add_dec  = ram_add - 1'b1;
    assign mismatch = pipe_vld[RD_LAT-1] && (ram_data_out != pipe_exp[RD_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            // The registered state still names the phase of the read on the RAM port.
            pipe_vld[0]  <= ram_rd;
            pipe_addr[0] <= ram_add;
            pipe_exp[0]  <= (state == RD_DN) ? ~pat(ram_add) : pat(ram_add);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    always_comb begin
        state_n     = state;
        drain_n     = drain_cnt;
        busy_n      = busy;
        done_n      = 1'b0;
        pass_n      = pass;
        err_n       = err_cnt + (AW+2)'(mismatch);
        fail_addr_n = fail_addr;
        fail_data_n = fail_data;
        wr_n        = 1'b0;
        rd_n        = 1'b0;
        add_n       = '0;
        din_n       = '0;
        if (mismatch && (err_cnt == '0)) begin
            fail_addr_n = pipe_addr[RD_LAT-1];
            fail_data_n = ram_data_out;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = WR_UP;
                    busy_n      = 1'b1;
                    pass_n      = 1'b0;
                    err_n       = '0;
                    fail_addr_n = '0;
                    fail_data_n = '0;
                    wr_n        = 1'b1;
                    din_n       = pat('0);
                end
            end
            WR_UP: begin
                if (ram_add == ADDR_MAX) begin
                    state_n = RD_UP;
                    rd_n    = 1'b1;
                end else begin
                    wr_n  = 1'b1;
                    add_n = add_inc;
                    din_n = pat(add_inc);
                end
            end
            RD_UP: begin
                if (ram_add == ADDR_MAX) begin
                    state_n = WR_DN;
                    wr_n    = 1'b1;
                    add_n   = ADDR_MAX;
                    din_n   = ~pat(ADDR_MAX);
                end else begin
                    rd_n  = 1'b1;
                    add_n = add_inc;
                end
            end
            WR_DN: begin
                if (ram_add == '0) begin
                    state_n = RD_DN;
                    rd_n    = 1'b1;
                    add_n   = ADDR_MAX;
                end else begin
                    wr_n  = 1'b1;
                    add_n = add_dec;
                    din_n = ~pat(add_dec);
                end
            end
            RD_DN: begin
                if (ram_add == '0) begin
                    state_n = DRAIN;
                    drain_n = 3'(RD_LAT - 1);
                end else begin
                    rd_n  = 1'b1;
                    add_n = add_dec;
                end
            end
            DRAIN: begin
                // err_n already includes a compare landing on this edge.
                if (drain_cnt == '0) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    pass_n  = (err_n == '0);
                end else begin
                    drain_n = drain_cnt - 3'd1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            ram_wr      <= 1'b0;
            ram_rd      <= 1'b0;
            ram_add     <= '0;
            ram_data_in <= '0;
        end else begin
            state       <= state_n;
            drain_cnt   <= drain_n;
            busy        <= busy_n;
            done        <= done_n;
            pass        <= pass_n;
            err_cnt     <= err_n;
            fail_addr   <= fail_addr_n;
            fail_data   <= fail_data_n;
            ram_wr      <= wr_n;
            ram_rd      <= rd_n;
            ram_add     <= add_n;
            ram_data_in <= din_n;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (1- and 2-cycle RAM models with injectable faults),
// RAM port sequence checked from an expected queue, results checked at done.
module tb_ram_bist_ctrl;

  logic clk, rst_n, start_a, start_b, sel;
  int   fault_a, fault_b;
  int   errors, checks;

  logic       a_busy, a_done, a_pass, a_wr, a_rd;
  logic [4:0] a_err;
  logic [2:0] a_fa, a_add;
  logic [7:0] a_fd, a_din, a_dout;
  logic       b_busy, b_done, b_pass, b_wr, b_rd;
  logic [4:0] b_err;
  logic [2:0] b_fa, b_add;
  logic [7:0] b_fd, b_din, b_dout, b_d1;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];

  logic [12:0] exp_q[$];

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_bist_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_cnt(a_err), .fail_addr(a_fa), .fail_data(a_fd), .ram_wr(a_wr), .ram_rd(a_rd),
    .ram_add(a_add), .ram_data_in(a_din), .ram_data_out(a_dout)
  );

  ram_bist_ctrl #(.RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_cnt(b_err), .fail_addr(b_fa), .fail_data(b_fd), .ram_wr(b_wr), .ram_rd(b_rd),
    .ram_add(b_add), .ram_data_in(b_din), .ram_data_out(b_dout)
  );

  // Faults: 1 = addr5 bit0 stuck-at-0, 2 = write to 3 also lands on 2, 3 = addr0 bit7 stuck-at-1
  function automatic logic [7:0] fault_wr(input int f, input logic [2:0] a, input logic [7:0] d);
    if (f == 1 && a == 3'd5) return d & 8'hFE;
    if (f == 3 && a == 3'd0) return d | 8'h80;
    return d;
  endfunction

  always @(posedge clk) begin
    if (a_wr) begin
      mem_a[a_add] <= fault_wr(fault_a, a_add, a_din);
      if (fault_a == 2 && a_add == 3'd3) mem_a[2] <= a_din;
    end
    if (a_rd) a_dout <= mem_a[a_add];
  end

  always @(posedge clk) begin
    if (b_wr) begin
      mem_b[b_add] <= fault_wr(fault_b, b_add, b_din);
      if (fault_b == 2 && b_add == 3'd3) mem_b[2] <= b_din;
    end
    if (b_rd) b_d1 <= mem_b[b_add];
    b_dout <= b_d1;
  end

  logic        m_busy, m_done, m_pass;
  logic [4:0]  m_err;
  logic [2:0]  m_fa;
  logic [7:0]  m_fd;
  logic [12:0] m_port;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_pass = sel ? b_pass : a_pass;
  assign m_err  = sel ? b_err  : a_err;
  assign m_fa   = sel ? b_fa   : a_fa;
  assign m_fd   = sel ? b_fd   : a_fd;
  assign m_port = sel ? {b_wr, b_rd, b_add, b_din} : {a_wr, a_rd, a_add, a_din};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Runs one march; reset_at > 0 aborts with reset in that cycle, repulse_at re-pulses start.
  task automatic run_test(input int exp_lat, input int exp_err, input int exp_fa, input int exp_fd,
                          input int repulse_at, input int reset_at);
    int done_at;
    logic [12:0] e, got;
    done_at = 0;
    exp_q.delete();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 8; i++) begin
        logic [2:0] a;
        logic [7:0] d;
        logic w;
        a = (ph < 2) ? 3'(i) : 3'(7 - i);
        w = (ph == 0) || (ph == 2);
        d = {5'd0, a} + 8'd1;
        if (ph == 2) d = ~d;
        if (!w) d = 8'h00;
        exp_q.push_back({w, ~w, a, d});
      end
    end
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == repulse_at) set_start(1'b1);
      if (n == repulse_at + 1) set_start(1'b0);
      if (n == 1) check("busy_start", 32'(m_busy), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = e[12] ? m_port : {m_port[12:8], 8'h00};
        check($sformatf("port_c%0d", n), 32'(got), 32'(e));
      end
      if (n == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_ram_wr_rd", 32'({a_wr, a_rd}), 32'd0);
        repeat (2) begin
          @(negedge clk);
          check("rst_no_done", 32'(m_done), 32'd0);
        end
        rst_n = 1'b1;
        check("rst_pass", 32'(m_pass), 32'd0);
        exp_q.delete();
        return;
      end
      if (m_done) begin
        done_at = n;
        break;
      end
    end
    check("done_latency", 32'(done_at), 32'(exp_lat));
    check("pass", 32'(m_pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check("err_cnt", 32'(m_err), 32'(exp_err));
    check("fail_addr", 32'(m_fa), 32'(exp_fa));
    check("fail_data", 32'(m_fd), 32'(exp_fd));
    check("busy_at_done", 32'(m_busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(m_done), 32'd0);
    check("pass_held", 32'(m_pass), (exp_err == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    fault_a = 0; fault_b = 0;
    repeat (3) @(negedge clk);
    check("rst_a_out", 32'({a_busy, a_done, a_pass, a_err, a_fa, a_fd}), 32'd0);
    check("rst_a_ram", 32'({a_wr, a_rd, a_add, a_din}), 32'd0);
    check("rst_b_out", 32'({b_busy, b_done, b_pass, b_err, b_fa, b_fd}), 32'd0);
    check("rst_b_ram", 32'({b_wr, b_rd, b_add, b_din}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean march, RD_LAT=1
    run_test(34, 0, 0, 8'h00, -1, -1);
    // Stuck bit at addr 5: only the inverted pass sees it
    fault_a = 1;
    run_test(34, 1, 5, 8'hF8, -1, -1);
    // Aliased write 3 -> 2: caught in the ascending read
    fault_a = 2;
    run_test(34, 1, 2, 8'h04, -1, -1);
    // start re-pulsed mid-test is ignored
    fault_a = 0;
    run_test(34, 0, 0, 8'h00, 10, -1);
    // Reset during RD_UP, then a fresh clean test
    run_test(34, 0, 0, 8'h00, -1, 12);
    @(negedge clk);
    run_test(34, 0, 0, 8'h00, -1, -1);

    // RD_LAT=2 instance: clean, then fault at addr 0
    sel = 1'b1;
    @(negedge clk);
    run_test(35, 0, 0, 8'h00, -1, -1);
    fault_b = 3;
    run_test(35, 1, 0, 8'h81, -1, -1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
